// File: rtl/pipe_hazard_ctrl.sv
// Control decode, EX/MEM/WB control shift register, destination scoreboard and
// hazard/freeze logic for the 5-stage RV32I pipeline.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MEM_LAT  = 1,
  parameter int BR_IN_ID = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] instr_in,
  input  logic        mispredict,
  input  logic        ext_stall,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_en,
  output logic        em_en,
  output logic        mw_en,
  output logic        ex_a_sel,
  output logic        ex_b_sel,
  output logic        mem_we,
  output logic        mem_re,
  output logic [1:0]  wb_sel,
  output logic        rf_we
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  typedef struct packed {
    logic       a_sel;
    logic       b_sel;
    logic       we;
    logic       re;
    logic [1:0] wb_sel;
    logic       rf_we;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } stage_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  stage_t            ex, mem, wb, id_stage;
  logic              wb_fresh;

  logic              id_ok, uses1, uses2, writes, is_br, is_ld;
  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              h1, h2, h3, stall, bubble, frozen;
  logic              unused_bits;

  assign unused_bits = ^{instr_in[31:25], instr_in[14:12]};

  always_comb begin
    id_ok   = 1'b1;
    id_ctrl = '0;
    uses1   = 1'b0;
    uses2   = 1'b0;
    writes  = 1'b0;
    is_br   = 1'b0;
    is_ld   = 1'b0;
    case (instr_in[6:0])
      7'b0000011: begin id_ctrl = ctrl_t'(7'b0101011); uses1 = 1'b1; writes = 1'b1; is_ld = 1'b1; end
      7'b0100011: begin id_ctrl = ctrl_t'(7'b0110000); uses1 = 1'b1; uses2 = 1'b1; end
      7'b1100011: begin uses1 = 1'b1; uses2 = 1'b1; is_br = 1'b1; end
      7'b1101111: begin id_ctrl = ctrl_t'(7'b1100101); writes = 1'b1; end
      7'b1100111: begin id_ctrl = ctrl_t'(7'b0100101); uses1 = 1'b1; writes = 1'b1; is_br = 1'b1; end
      7'b0010011: begin id_ctrl = ctrl_t'(7'b0100001); uses1 = 1'b1; writes = 1'b1; end
      7'b0110011: begin id_ctrl = ctrl_t'(7'b0000001); uses1 = 1'b1; uses2 = 1'b1; writes = 1'b1; end
      7'b0110111,
      7'b0010111: begin id_ctrl = ctrl_t'(7'b1100001); writes = 1'b1; end
      7'b0001111,
      7'b1110011: ;
      default:    id_ok = 1'b0;
    endcase
  end

  // Unused source fields are zeroed so that an rd match can never fire on them.
  assign rs1 = uses1  ? instr_in[15 +: REG_AW] : '0;
  assign rs2 = uses2  ? instr_in[20 +: REG_AW] : '0;
  assign rd  = writes ? instr_in[7  +: REG_AW] : '0;

  function automatic logic hit(input logic [REG_AW-1:0] d,
                               input logic [REG_AW-1:0] a,
                               input logic [REG_AW-1:0] b);
    return (d != '0) && ((d == a) || (d == b));
  endfunction

  assign h1    = ex.valid && ex.is_load && hit(ex.rd, rs1, rs2);
  assign h2    = (BR_IN_ID != 0) && is_br && ex.valid && hit(ex.rd, rs1, rs2);
  assign h3    = (BR_IN_ID != 0) && is_br && mem.valid && mem.is_load && hit(mem.rd, rs1, rs2);
  assign stall = h1 || h2 || h3;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    frozen  = !nrst || ext_stall || (state == MEM_WAIT);
    pc_en   = 1'b0;
    fd_en   = 1'b0;
    de_en   = 1'b0;
    em_en   = 1'b0;
    mw_en   = 1'b0;
    bubble  = mispredict || stall;
    if (!frozen) begin
      pc_en = mispredict || !stall;
      fd_en = mispredict || !stall;
      de_en = 1'b1;
      em_en = 1'b1;
      mw_en = 1'b1;
    end
    if (!ext_stall) begin
      case (state)
        RUN: begin
          if (MEM_LAT > 1 && ex.valid && (ex.ctrl.we || ex.ctrl.re)) begin
            state_n = MEM_WAIT;
            cnt_n   = 4'd1;
          end
        end
        MEM_WAIT: begin
          if (cnt == LAST_CNT) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_comb begin
    id_stage         = '0;
    id_stage.valid   = id_ok && !bubble;
    if (id_stage.valid) begin
      id_stage.ctrl    = id_ctrl;
      id_stage.rd      = rd;
      id_stage.is_load = is_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= RUN;
      cnt      <= '0;
      ex       <= '0;
      mem      <= '0;
      wb       <= '0;
      wb_fresh <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      if (de_en) ex  <= id_stage;
      if (em_en) mem <= ex;
      if (mw_en) wb  <= mem;
      // rf_we only in the first cycle a WB entry is held, so a frozen WB cannot rewrite.
      wb_fresh <= mw_en;
    end
  end

  assign ex_a_sel = ex.valid  && ex.ctrl.a_sel;
  assign ex_b_sel = ex.valid  && ex.ctrl.b_sel;
  assign mem_we   = mem.valid && mem.ctrl.we;
  assign mem_re   = mem.valid && mem.ctrl.re;
  assign wb_sel   = wb.valid ? wb.ctrl.wb_sel : 2'b00;
  assign rf_we    = wb.valid && wb.ctrl.rf_we && wb_fresh;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench: three instances (default, BR_IN_ID=0, MEM_LAT=4)
// driven cycle by cycle, the bench playing the role of the IF/ID register.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111, OPIMM = 7'b0010011, OP     = 7'b0110011;

  logic        clk;
  logic        nrst  [3];
  logic [31:0] instr [3];
  logic        mis   [3];
  logic        ext   [3];
  logic        pc_en [3], fd_en [3], de_en [3], em_en [3], mw_en [3];
  logic        ex_a_sel [3], ex_b_sel [3], mem_we [3], mem_re [3], rf_we [3];
  logic [1:0]  wb_sel [3];
  logic [4:0]  en [3];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_hazard_ctrl #(
      .REG_AW  (5),
      .MEM_LAT (g == 2 ? 4 : 1),
      .BR_IN_ID(g == 1 ? 0 : 1)
    ) dut (
      .clk       (clk),
      .nrst      (nrst[g]),
      .instr_in  (instr[g]),
      .mispredict(mis[g]),
      .ext_stall (ext[g]),
      .pc_en     (pc_en[g]),
      .fd_en     (fd_en[g]),
      .de_en     (de_en[g]),
      .em_en     (em_en[g]),
      .mw_en     (mw_en[g]),
      .ex_a_sel  (ex_a_sel[g]),
      .ex_b_sel  (ex_b_sel[g]),
      .mem_we    (mem_we[g]),
      .mem_re    (mem_re[g]),
      .wb_sel    (wb_sel[g]),
      .rf_we     (rf_we[g])
    );
    assign en[g] = {pc_en[g], fd_en[g], de_en[g], em_en[g], mw_en[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int d, input logic [31:0] i, input logic m, input logic e);
    instr[d] = i;
    mis[d]   = m;
    ext[d]   = e;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      nrst[i] = 1'b0; instr[i] = '0; mis[i] = 1'b0; ext[i] = 1'b0;
    end
    cyc(); cyc();
    chk("reset_en", 32'(en[0]), 32'h00);
    chk("reset_rf_we", 32'(rf_we[0]), 32'h0);
    chk("reset_mem_we", 32'(mem_we[2]), 32'h0);
    for (int i = 0; i < 3; i++) nrst[i] = 1'b1;
    #1;
    chk("release_en", 32'(en[0]), 32'h1f);

    // back-to-back ALU ops: no stall, one rf_we pulse each
    put(0, ins(OP, 3, 1, 2), 0, 0); chk("add_a_en", 32'(en[0]), 32'h1f); cyc();
    put(0, ins(OP, 4, 3, 3), 0, 0); chk("add_b_en", 32'(en[0]), 32'h1f); cyc();
    put(0, '0, 0, 0); cyc();
    chk("add_a_rf_we", 32'(rf_we[0]), 32'h1); chk("add_a_wb_sel", 32'(wb_sel[0]), 32'h0); cyc();
    chk("add_b_rf_we", 32'(rf_we[0]), 32'h1); cyc();
    chk("add_idle_rf_we", 32'(rf_we[0]), 32'h0);

    // load-use
    put(0, ins(LOAD, 5, 1, 0), 0, 0); chk("lu_lw_en", 32'(en[0]), 32'h1f); cyc();
    put(0, ins(OP, 6, 5, 2), 0, 0);
    chk("lu_stall_en", 32'(en[0]), 32'h07); chk("lu_ex_b_sel", 32'(ex_b_sel[0]), 32'h1); cyc();
    chk("lu_go_en", 32'(en[0]), 32'h1f); chk("lu_mem_re", 32'(mem_re[0]), 32'h1);
    chk("lu_bubble_ex", 32'(ex_b_sel[0]), 32'h0); cyc();
    put(0, '0, 0, 0);
    chk("lu_lw_wb_sel", 32'(wb_sel[0]), 32'h1); chk("lu_lw_rf_we", 32'(rf_we[0]), 32'h1); cyc();
    chk("lu_bubble_rf_we", 32'(rf_we[0]), 32'h0); cyc();
    chk("lu_add_rf_we", 32'(rf_we[0]), 32'h1); chk("lu_add_wb_sel", 32'(wb_sel[0]), 32'h0);

    // branch after load (2 stalls) and after ALU (1 stall), operands in ID
    put(0, ins(LOAD, 7, 1, 0), 0, 0); cyc();
    put(0, ins(BRANCH, 0, 7, 0), 0, 0); chk("bl_stall1", 32'(en[0]), 32'h07); cyc();
    chk("bl_stall2", 32'(en[0]), 32'h07); cyc();
    chk("bl_go", 32'(en[0]), 32'h1f); cyc();
    put(0, ins(OPIMM, 7, 1, 0), 0, 0); cyc();
    put(0, ins(BRANCH, 0, 7, 0), 0, 0); chk("ba_stall1", 32'(en[0]), 32'h07); cyc();
    chk("ba_go", 32'(en[0]), 32'h1f); cyc();
    // x0 destination never hazards
    put(0, ins(LOAD, 0, 1, 0), 0, 0); cyc();
    put(0, ins(OP, 6, 0, 2), 0, 0); chk("x0_no_stall", 32'(en[0]), 32'h1f); cyc();
    put(0, '0, 0, 0);

    // BR_IN_ID=0: ALU->branch free, load->branch only load-use
    put(1, ins(OPIMM, 7, 1, 0), 0, 0); cyc();
    put(1, ins(BRANCH, 0, 7, 0), 0, 0); chk("nb_alu_go", 32'(en[1]), 32'h1f); cyc();
    put(1, ins(LOAD, 7, 1, 0), 0, 0); cyc();
    put(1, ins(BRANCH, 0, 7, 0), 0, 0); chk("nb_ld_stall", 32'(en[1]), 32'h07); cyc();
    chk("nb_ld_go", 32'(en[1]), 32'h1f); cyc();
    put(1, '0, 0, 0);

    // mispredict overrides load-use; EX receives a bubble
    put(0, ins(LOAD, 5, 1, 0), 0, 0); cyc();
    put(0, ins(OPIMM, 6, 5, 0), 1, 0); chk("mp_en", 32'(en[0]), 32'h1f); cyc();
    put(0, '0, 0, 0);
    chk("mp_ex_bubble", 32'(ex_b_sel[0]), 32'h0); chk("mp_lw_mem_re", 32'(mem_re[0]), 32'h1); cyc();
    chk("mp_lw_rf_we", 32'(rf_we[0]), 32'h1); cyc();
    chk("mp_bubble_rf_we", 32'(rf_we[0]), 32'h0);

    // external freeze
    put(0, ins(OPIMM, 6, 1, 0), 0, 1); chk("ext_en", 32'(en[0]), 32'h00); cyc();
    put(0, ins(OPIMM, 6, 1, 0), 0, 0); chk("ext_rel_en", 32'(en[0]), 32'h1f);
    chk("ext_held_ex", 32'(ex_b_sel[0]), 32'h0); cyc();
    put(0, '0, 0, 0); chk("ext_ex_b_sel", 32'(ex_b_sel[0]), 32'h1);

    // JAL: PC operand, PC+4 writeback
    put(0, ins(JAL, 1, 0, 0), 0, 0); cyc();
    put(0, '0, 0, 0);
    chk("jal_a_sel", 32'(ex_a_sel[0]), 32'h1); chk("jal_b_sel", 32'(ex_b_sel[0]), 32'h1); cyc(); cyc();
    chk("jal_wb_sel", 32'(wb_sel[0]), 32'h2); chk("jal_rf_we", 32'(rf_we[0]), 32'h1);

    // MEM_LAT=4 store with an ALU op ahead of it in WB
    put(2, ins(OPIMM, 1, 1, 0), 0, 0); chk("ml_c0_en", 32'(en[2]), 32'h1f); cyc();
    put(2, ins(STORE, 0, 1, 2), 0, 0); chk("ml_c1_en", 32'(en[2]), 32'h1f); cyc();
    put(2, '0, 0, 0); chk("ml_c2_en", 32'(en[2]), 32'h1f); cyc();
    for (int k = 0; k < 3; k++) begin
      chk("ml_wait_en", 32'(en[2]), 32'h00);
      chk("ml_wait_mem_we", 32'(mem_we[2]), 32'h1);
      chk("ml_wait_rf_we", 32'(rf_we[2]), (k == 0) ? 32'h1 : 32'h0);
      cyc();
    end
    chk("ml_run_en", 32'(en[2]), 32'h1f); chk("ml_run_mem_we", 32'(mem_we[2]), 32'h1);
    chk("ml_run_rf_we", 32'(rf_we[2]), 32'h0); cyc();
    chk("ml_done_mem_we", 32'(mem_we[2]), 32'h0);

    // reset during MEM_WAIT
    put(2, ins(STORE, 0, 1, 2), 0, 0); cyc();
    put(2, '0, 0, 0); cyc();
    chk("rw_wait_en", 32'(en[2]), 32'h00);
    nrst[2] = 1'b0; cyc();
    chk("rw_mem_we", 32'(mem_we[2]), 32'h0); chk("rw_en", 32'(en[2]), 32'h00);
    nrst[2] = 1'b1; #1;
    chk("rw_rel_en", 32'(en[2]), 32'h1f);
    put(2, ins(STORE, 0, 1, 2), 0, 0); cyc();
    put(2, '0, 0, 0); cyc();
    for (int k = 0; k < 3; k++) begin
      chk("rw_again_wait_en", 32'(en[2]), 32'h00);
      cyc();
    end
    chk("rw_again_run_en", 32'(en[2]), 32'h1f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised control and hazard unit for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It decodes the ID-stage instruction into a per-stage control word and carries that word down an EX/MEM/WB shift register. It keeps a register-destination scoreboard of in-flight instructions, inserts bubbles for load-use and branch-operand hazards, freezes the pipeline for a configurable data-memory latency, and squashes the ID instruction on a branch mispredict.

## Interface
- REG_AW, 5, register-index width
- MEM_LAT, 1, cycles per data-memory access (1..15); 1 means no wait
- BR_IN_ID, 1, 1 = branch/JALR operands read in ID (branch hazards apply); 0 = resolved in EX (load-use rule only)
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- instr_in  in  32  instruction in IF/ID register
- mispredict  in  1  BPU mispredict; squash ID instruction
- ext_stall  in  1  external freeze (I-cache miss)
- pc_en, fd_en, de_en, em_en, mw_en  out  1 each  PC and pipeline-register enables
- ex_a_sel  out  1  0 = rs1, 1 = PC
- ex_b_sel  out  1  0 = rs2, 1 = imm
- mem_we, mem_re  out  1 each  data-memory write/read strobes (MEM stage)
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4
- rf_we  out  1  register-file write (WB stage)

## Operation
- Decode (ID) by opcode to {a_sel, b_sel, we, re, wb_sel, rf_we, uses_rs1, uses_rs2, writes_rd}:
  - LOAD 0000011 {0,1,0,1,01,1}
  - STORE 0100011 {0,1,1,0,00,0}
  - BRANCH 1100011 {0,0,0,0,00,0}
  - JAL 1101111 {1,1,0,0,10,1}
  - JALR 1100111 {0,1,0,0,10,1}
  - OP-IMM 0010011 {0,1,0,0,00,1}
  - OP 0110011 {0,0,0,0,00,1}
  - LUI/AUIPC {1,1,0,0,00,1}
  - FENCE/SYSTEM: NOP
  - Any other opcode (including 0): bubble; pc_en stays 1.
- Register fields:
  - rs1 = instr[19:15] unless JAL/LUI/AUIPC.
  - rs2 = instr[24:20] only for OP, STORE, BRANCH.
  - rd = instr[11:7] only when writes_rd.
  - A field of value 0 never creates a hazard.
- Scoreboard entries for EX, MEM, WB: {valid, rd, is_load}. They shift with the control word.
- Hazards against the ID instruction (combinational, from the current scoreboard):
  - H1 load-use: EX.is_load and EX.rd matches a used rs.
  - H2 (BR_IN_ID=1, ID is BRANCH/JALR): EX.valid and EX.rd matches.
  - H3 (BR_IN_ID=1, ID is BRANCH/JALR): MEM.is_load and MEM.rd matches.
- Any of H1/H2/H3 causes a stall: pc_en=fd_en=0, a bubble enters EX, and EX→MEM→WB keep advancing.
- mispredict (not frozen): the ID instruction becomes a bubble; all enables stay 1. Mispredict overrides the hazard stall.
- FSM:
  - RUN: a LOAD/STORE entering MEM with MEM_LAT>1 → MEM_WAIT, counter=1.
  - MEM_WAIT: all enables 0, counter increments; at counter==MEM_LAT-1 → RUN.
  - ext_stall=1 in either state freezes everything: all enables 0, counter held.
- Control outputs are read from the stage registers:
  - EX stage: a_sel, b_sel.
  - MEM stage: we, re.
  - WB stage: wb_sel, rf_we.
  - Each stage's outputs are gated by its valid bit.
  - During MEM_WAIT, mem_we/mem_re stay asserted. rf_we is forced to 0 after the first WB cycle so it cannot double-write.

## Timing
- Reset (nrst=0 at clk edge):
  - All valids, counter and outputs 0.
  - State RUN.
  - First cycle after release: pc_en=fd_en=1.
- Decode→EX control latency: 1 cycle. Instruction in ID at cycle n drives ex_* at n+1, mem_* at n+2, wb_sel/rf_we at n+3 (with MEM_LAT=1).
- Stall signals and enables are combinational in the same cycle as the ID instruction.
- Stall durations:
  - Load-use: 1 cycle.
  - Branch after ALU: 1 cycle.
  - Branch after load: 2 cycles (H1-equivalent via EX, then H3).
- Each memory op in MEM adds MEM_LAT-1 freeze cycles.
- Counter is 4 bits and never wraps (MEM_LAT ≤ 15).
- Simultaneous events, priority order: reset > ext_stall > MEM_WAIT > mispredict > hazard stall.
- mispredict asserted during a freeze is ignored; the BPU holds it until the first non-frozen cycle.

## Test plan
- Reset, then OP x3=x1+x2 followed by OP x4=x3+x3 → no stall; rf_we pulses 1 cycle for each, 1 cycle apart.
- LW x5,0(x1) then ADD x6,x5,x2 → pc_en=0 for exactly 1 cycle; ADD reaches EX 2 cycles after LW.
- BR_IN_ID=1: LW x7 then BEQ x7,x0 → 2 stall cycles. ADDI x7 then BEQ x7,x0 → 1 stall cycle. BR_IN_ID=0, same pair → 0 stalls.
- MEM_LAT=4, SW in MEM → all enables 0 for 3 cycles, mem_we=1 for 4 cycles, then RUN.
- mispredict=1 together with a load-use hazard → no stall; EX receives a bubble (ex/mem/wb controls 0 downstream).
- nrst=0 mid MEM_WAIT → next cycle all outputs 0, state RUN, counter 0.
